dm_responder: RTL

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, fixed-latency response with byte/half/word lanes.
// Define DM_WRITE_LOG_EN to print one line per successful store at its write edge.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        init_q;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, access;
  logic [31:0] mem_q [2**ADDR_W];

  // With LATENCY=1 the access happens on the acceptance edge, so operands come straight from the inputs.
  logic        a_we;
  logic [2:0]  a_sel;
  logic [31:0] a_addr, a_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0] cur_word, merged;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic [4:0]  bsh, hsh;

  assign req_ready  = init_q && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  assign a_we     = (state_q == IDLE) ? req_we    : we_q;
  assign a_sel    = (state_q == IDLE) ? req_sel   : sel_q;
  assign a_addr   = (state_q == IDLE) ? req_addr  : addr_q;
  assign a_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
  assign word_idx = a_addr[ADDR_W+1:2];
  assign cur_word = mem_q[word_idx];
  assign bsh      = {a_addr[1:0], 3'b000};
  assign hsh      = {a_addr[1], 4'b0000};
  assign half_v   = a_addr[1] ? cur_word[31:16] : cur_word[15:0];
  assign byte_v   = 8'(cur_word >> bsh);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = (a_sel > 3'd4) || (|a_addr[31:ADDR_W+2]) ||
            ((a_sel == 3'd0) && (a_addr[1:0] != 2'b00)) ||
            ((a_sel == 3'd1 || a_sel == 3'd2) && a_addr[0]);
    merged  = cur_word;
    rdata_d = 32'd0;
    case (a_sel)
      3'd0: merged = a_wdata;
      3'd1, 3'd2: merged = (cur_word & ~(32'h0000_FFFF << hsh)) | ({16'd0, a_wdata[15:0]} << hsh);
      3'd3, 3'd4: merged = (cur_word & ~(32'h0000_00FF << bsh)) | ({24'd0, a_wdata[7:0]} << bsh);
      default: merged = cur_word;
    endcase
    if (!a_we && !err_d) begin
      case (a_sel)
        3'd0: rdata_d = cur_word;
        3'd1: rdata_d = {{16{half_v[15]}}, half_v};
        3'd2: rdata_d = {16'd0, half_v};
        3'd3: rdata_d = {{24{byte_v[7]}}, byte_v};
        3'd4: rdata_d = {24'd0, byte_v};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      init_q  <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        sel_q   <= req_sel;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Memory is cleared while reset is held; an aborted access never reaches its write edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= 32'd0;
    end else if (access && a_we && !err_d) begin
      mem_q[word_idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q;
  logic [31:0] a_pc;
  assign a_pc = (state_q == IDLE) ? req_pc : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'd0;
    end else begin
      if (accept) pc_q <= req_pc;
      if (access && a_we && !err_d)
        $display("@%08h: *%08h <= %08h", a_pc, {a_addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule
